booth_radix4_mult: RTL and testbench
====================================

// Module: booth_radix4_mult
// PURPOSE
//  Sequential radix-4 (modified) Booth multiplier, successor to the radix-2 Booth unit.
//  Parametrised operand width; per-operation signed/unsigned mode.
//  Retires two multiplier bits per cycle, with fixed latency.
//  start/valid/busy handshake; drop-in datapath multiplier for the RTL series.
// PARAMETERS
//  WIDTH  8  operand width in bits; must be even and >= 4 (elaboration-time $error otherwise)
// PORTS
//  clk        input   1          rising-edge clock
//  reset      input   1          asynchronous, active-low reset
//  start      input   1          request; sampled only when busy=0
//  is_signed  input   1          1: M,Q two's complement; 0: M,Q unsigned; sampled with start
//  M          input   WIDTH      multiplicand; sampled with start
//  Q          input   WIDTH      multiplier; sampled with start
//  Y          output  2*WIDTH    product (signed or unsigned per latched mode)
//  valid      output  1          one-cycle pulse: Y holds a new product
//  busy       output  1          high while an operation is in progress
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, Y=0, valid=0, busy=0, internal accumulators cleared.
//  Operand extension: M,Q extended to WIDTH+2 bits on accept.
//    Sign-extended if is_signed=1; zero-extended if is_signed=0.
//    This makes the unsigned full range exact.
//  Iterations: N=(WIDTH+2)/2, independent of mode (N=5 for WIDTH=8).
//  States: IDLE, CALC, DONE.
//  IDLE:
//    start=1 at edge t0 latches operands and mode; clears acc; appends Q[-1]=0.
//    busy=1 from t0; count=0; go to CALC.
//  CALC, each cycle:
//    Recode triplet {Q[1],Q[0],Q[-1]} into digit 0,+1M,+2M,-1M,-2M.
//      000,111 -> 0;  001,010 -> +M;  011 -> +2M;  100 -> -2M;  101,110 -> -M.
//    Add digit to the upper half of the (WIDTH+2)+(WIDTH+3)-bit acc|Q register.
//    Arithmetic-shift the whole register right by 2.
//    Partial-sum width WIDTH+3 so that +/-2M never overflows.
//    After N iterations, go to DONE.
//  DONE (one cycle):
//    Y <= low 2*WIDTH bits of the product; valid=1; busy=0; next state IDLE.
//    valid is high exactly at edge t0+N+1; latency start->valid = N+1 clocks.
//  Y holds its value until the next valid pulse.
//    Y is not cleared by start; it is only cleared by reset.
//  start while busy=1 (CALC): ignored; no queuing; in-flight operands unaffected.
//  start in DONE cycle: ignored; must be re-asserted once busy=0.
//    Back-to-back throughput is one op per N+2 clocks.
//  Input changes on M/Q/is_signed while busy: no effect on the result.
//  Reset mid-operation: immediate abort; all outputs return to reset values; no valid pulse.
//  Corner cases must be exact:
//    signed MIN*MIN = +2^(2W-2);  unsigned MAX*MAX = (2^W-1)^2.
//    Any operand 0 gives 0.
// TESTING
//  T1:
//    WIDTH=8, signed, M=5, Q=7.
//    -> valid 6 clocks after start edge; Y=35 (0x0023).
//  T2:
//    Signed M=-4, Q=6 -> Y=-24 (0xFFE8).
//    Signed M=-3, Q=-5 -> Y=15.
//    Signed M=-128, Q=-128 -> Y=16384 (0x4000).
//  T3:
//    Unsigned M=255, Q=255 -> Y=65025 (0xFE01).
//    Same bits with is_signed=1 -> Y=1.
//  T4:
//    Start M=5, Q=7; pulse start again at +2 clocks with M=9, Q=9.
//    -> single valid; Y=35; busy stays high; second request dropped.
//  T5:
//    Start M=100, Q=3; assert reset=0 at +3 clocks.
//    -> Y=0, valid=0, busy=0 immediately; no valid after release.
//    Next op (M=2, Q=-8) -> Y=-16 (0xFFF0).
//  T6:
//    WIDTH=4 build, signed M=2, Q=-8 -> Y=-16 (0xF0), valid 4 clocks after start.
//    Random 1000-op sweep both modes vs M*Q reference model.

Source files
------------

// File: rtl/booth_radix4_mult.sv
// booth_radix4_mult: sequential radix-4 Booth multiplier with signed/unsigned mode and start/valid/busy handshake
module booth_radix4_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   M,
    input  logic [WIDTH-1:0]   Q,
    output logic [2*WIDTH-1:0] Y,
    output logic               valid,
    output logic               busy
);
    localparam int N  = (WIDTH + 2) / 2;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state, state_d;
    logic [WIDTH+1:0]    m, q;
    logic [WIDTH+2:0]    acc, dm, sum;
    logic                qm1;
    logic [CW-1:0]       count;
    logic [2:0]          trip;
    logic [2*WIDTH+5:0]  shifted;

    if (WIDTH % 2 != 0 || WIDTH < 4) begin : g_bad_width
        $error("booth_radix4_mult: WIDTH must be even and >= 4");
    end

    // Recode the current triplet, add the digit to the upper half, then shift the whole register by two
    always_comb begin
        trip    = {q[1:0], qm1};
        dm      = (trip == 3'b011 || trip == 3'b100) ? {m, 1'b0} : {m[WIDTH+1], m};
        sum     = acc + ((trip == 3'b000 || trip == 3'b111) ? '0 : trip[2] ? -dm : dm);
        shifted = $signed({sum, q, qm1}) >>> 2;
    end

    // Next-state logic: accept in IDLE, iterate N times in CALC, retire in DONE
    always_comb begin
        state_d = state == IDLE ? (start ? CALC : IDLE)
                : state == CALC ? (count == CW'(N - 1) ? DONE : CALC)
                : IDLE;
    end

    // State register, datapath and registered handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            m     <= '0;
            q     <= '0;
            acc   <= '0;
            qm1   <= 1'b0;
            count <= '0;
            Y     <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_d;
            valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    m     <= is_signed ? {{2{M[WIDTH-1]}}, M} : {2'b00, M};
                    q     <= is_signed ? {{2{Q[WIDTH-1]}}, Q} : {2'b00, Q};
                    acc   <= '0;
                    qm1   <= 1'b0;
                    count <= '0;
                    busy  <= 1'b1;
                end
                CALC: begin
                    acc   <= shifted[2*WIDTH+5:WIDTH+3];
                    q     <= shifted[WIDTH+2:1];
                    qm1   <= shifted[0];
                    count <= count + 1'b1;
                end
                DONE: begin
                    Y     <= {acc[WIDTH-3:0], q};
                    valid <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_radix4_mult.sv
// tb_booth_radix4_mult: directed and random checks of the radix-4 Booth multiplier at WIDTH=8 and WIDTH=4
module tb_booth_radix4_mult;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start8 = 1'b0, sg8 = 1'b0, v8, b8;
    logic [7:0]  m8 = '0, q8 = '0;
    logic [15:0] y8;
    logic        start4 = 1'b0, sg4 = 1'b0, v4, b4;
    logic [3:0]  m4 = '0, q4 = '0;
    logic [7:0]  y4;
    int          n_cmp = 0, n_bad = 0;
    logic [15:0] last8 = '0;
    logic [7:0]  last4 = '0;

    typedef struct {
        logic        sg;
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] y;
    } vec_t;

    vec_t tv8[14];
    vec_t tv4[6];

    always #5 clk = ~clk;

    booth_radix4_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .is_signed(sg8),
        .M(m8), .Q(q8), .Y(y8), .valid(v8), .busy(b8)
    );

    booth_radix4_mult #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .is_signed(sg4),
        .M(m4), .Q(q4), .Y(y4), .valid(v4), .busy(b4)
    );

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ref8(input logic sg, input logic [7:0] a, input logic [7:0] b);
        int x, y;
        x = sg ? int'($signed(a)) : int'(a);
        y = sg ? int'($signed(b)) : int'(b);
        return 16'(x * y);
    endfunction

    function automatic logic [15:0] ref4(input logic sg, input logic [3:0] a, input logic [3:0] b);
        int x, y;
        x = sg ? int'($signed(a)) : int'(a);
        y = sg ? int'($signed(b)) : int'(b);
        return {8'h00, 8'(x * y)};
    endfunction

    // One full operation: start, scramble inputs while busy, wait bounded for valid, check latency and product
    task automatic op(input bit w4, input logic sg, input logic [7:0] m, input logic [7:0] q,
                      input logic [15:0] ey, input string nm);
        int cyc;
        @(negedge clk);
        if (w4) begin start4 = 1'b1; sg4 = sg; m4 = m[3:0]; q4 = q[3:0]; end
        else    begin start8 = 1'b1; sg8 = sg; m8 = m;      q8 = q;      end
        @(posedge clk); #1;
        chk({nm, " busy_t0"}, 16'(w4 ? b4 : b8), 16'd1);
        chk({nm, " y_hold"}, w4 ? {8'h00, y4} : y8, w4 ? {8'h00, last4} : last8);
        @(negedge clk);
        if (w4) begin start4 = 1'b0; sg4 = ~sg; m4 = ~m[3:0]; q4 = ~q[3:0]; end
        else    begin start8 = 1'b0; sg8 = ~sg; m8 = ~m;      q8 = ~q;      end
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!(w4 ? v4 : v8) && cyc < 20);
        chk({nm, " latency"}, 16'(cyc), w4 ? 16'd4 : 16'd6);
        chk({nm, " y"}, w4 ? {8'h00, y4} : y8, ey);
        chk({nm, " busy_done"}, 16'(w4 ? b4 : b8), 16'd0);
        if (w4) last4 = ey[7:0];
        else    last8 = ey;
    endtask

    initial begin
        int nv, first;
        logic [7:0] rm, rq;
        logic       rs;
        tv8[0]  = '{1'b1, 8'd5,   8'd7,   16'h0023};
        tv8[1]  = '{1'b1, 8'hFC,  8'd6,   16'hFFE8};
        tv8[2]  = '{1'b1, 8'hFD,  8'hFB,  16'h000F};
        tv8[3]  = '{1'b1, 8'h80,  8'h80,  16'h4000};
        tv8[4]  = '{1'b0, 8'hFF,  8'hFF,  16'hFE01};
        tv8[5]  = '{1'b1, 8'hFF,  8'hFF,  16'h0001};
        tv8[6]  = '{1'b1, 8'h00,  8'h80,  16'h0000};
        tv8[7]  = '{1'b0, 8'hFF,  8'h00,  16'h0000};
        tv8[8]  = '{1'b0, 8'h80,  8'h02,  16'h0100};
        tv8[9]  = '{1'b1, 8'h80,  8'h7F,  16'hC080};
        tv8[10] = '{1'b0, 8'h80,  8'h80,  16'h4000};
        tv8[11] = '{1'b1, 8'h7F,  8'h7F,  16'h3F01};
        tv8[12] = '{1'b1, 8'hFF,  8'h01,  16'hFFFF};
        tv8[13] = '{1'b0, 8'd200, 8'd3,   16'h0258};
        tv4[0]  = '{1'b1, 8'h2,   8'h8,   16'h00F0};
        tv4[1]  = '{1'b0, 8'hF,   8'hF,   16'h00E1};
        tv4[2]  = '{1'b1, 8'h8,   8'h8,   16'h0040};
        tv4[3]  = '{1'b1, 8'hF,   8'hF,   16'h0001};
        tv4[4]  = '{1'b0, 8'h0,   8'h9,   16'h0000};
        tv4[5]  = '{1'b1, 8'h7,   8'hF,   16'h00F9};

        #12;
        chk("rst y8", y8, 16'h0000);
        chk("rst valid8", 16'(v8), 16'd0);
        chk("rst busy8", 16'(b8), 16'd0);
        chk("rst y4", {8'h00, y4}, 16'h0000);
        chk("rst valid4", 16'(v4), 16'd0);
        chk("rst busy4", 16'(b4), 16'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 14; i++)
            op(1'b0, tv8[i].sg, tv8[i].m, tv8[i].q, tv8[i].y, $sformatf("w8 vec%0d", i));
        for (int i = 0; i < 6; i++)
            op(1'b1, tv4[i].sg, tv4[i].m, tv4[i].q, tv4[i].y, $sformatf("w4 vec%0d", i));

        // Second start while busy must be dropped
        @(negedge clk);
        start8 = 1'b1; sg8 = 1'b1; m8 = 8'd5; q8 = 8'd7;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b1; m8 = 8'd9; q8 = 8'd9;
        @(posedge clk); #1;
        chk("t4 busy_at_2", 16'(b8), 16'd1);
        @(negedge clk);
        start8 = 1'b0;
        nv = 0;
        first = 0;
        for (int c = 3; c <= 16; c++) begin
            @(posedge clk); #1;
            if (v8) begin
                nv++;
                if (first == 0) first = c;
            end
            if (c == 5) chk("t4 busy_at_5", 16'(b8), 16'd1);
        end
        chk("t4 valid_count", 16'(nv), 16'd1);
        chk("t4 valid_cycle", 16'(first), 16'd6);
        chk("t4 y", y8, 16'h0023);
        last8 = 16'h0023;

        // Reset in the middle of an operation aborts it
        @(negedge clk);
        start8 = 1'b1; sg8 = 1'b1; m8 = 8'd100; q8 = 8'd3;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t5 y_reset", y8, 16'h0000);
        chk("t5 valid_reset", 16'(v8), 16'd0);
        chk("t5 busy_reset", 16'(b8), 16'd0);
        @(negedge clk);
        reset = 1'b1;
        nv = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (v8) nv++;
        end
        chk("t5 no_valid", 16'(nv), 16'd0);
        chk("t5 y_still_zero", y8, 16'h0000);
        last8 = 16'h0000;
        last4 = 8'h00;
        op(1'b0, 1'b1, 8'd2, 8'hF8, 16'hFFF0, "t5 next");

        for (int i = 0; i < 1000; i++) begin
            rm = 8'($urandom);
            rq = 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            op(1'b0, rs, rm, rq, ref8(rs, rm, rq), $sformatf("w8 rnd%0d %h*%h s%0d", i, rm, rq, rs));
        end
        for (int i = 0; i < 200; i++) begin
            rm = 8'($urandom_range(0, 15));
            rq = 8'($urandom_range(0, 15));
            rs = 1'($urandom_range(0, 1));
            op(1'b1, rs, rm, rq, ref4(rs, rm[3:0], rq[3:0]), $sformatf("w4 rnd%0d %h*%h s%0d", i, rm, rq, rs));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
